// File: rtl/uart_prog_pkg.sv
// Shared definitions for the programming-link UART transmitter and receiver.
package uart_prog_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/prog_tx_fifo.sv
// Byte FIFO for the programming UART transmitter; first-word-fall-through read port.
module prog_tx_fifo #(
    parameter int unsigned FifoDepth = 8
) (
    input  logic                         clk_i,
    input  logic                         system_rst_ni,
    input  logic                         push_i,
    input  logic [7:0]                   data_i,
    input  logic                         pop_i,
    output logic [7:0]                   data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(FifoDepth):0]   level_o
);

    localparam int unsigned AddrW = $clog2(FifoDepth);
    localparam int unsigned LvlW  = AddrW + 1;

    logic [7:0]       mem [FifoDepth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic [LvlW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == LvlW'(FifoDepth));
    assign empty_o = (count == '0);
    assign level_o = count;
    assign data_o  = mem[rd_ptr];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i or negedge system_rst_ni) begin
        if (!system_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AddrW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + LvlW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - LvlW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_prog_transmitter.sv
// 8N1 UART transmitter with byte FIFO for the programming-link return path.
module uart_prog_transmitter
    import uart_prog_pkg::*;
#(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned ClkCntW   = 16
) (
    input  logic                         clk_i,
    input  logic                         system_rst_ni,
    input  logic [ClkCntW-1:0]           clks_per_bit_i,
    input  logic                         tx_valid_i,
    input  logic [7:0]                   tx_byte_i,
    output logic                         tx_ready_o,
    output logic                         tx_serial_o,
    output logic                         tx_active_o,
    output logic                         tx_done_o,
    output logic [$clog2(FifoDepth):0]   fifo_level_o
);

    tx_state_e          state_q;
    logic [ClkCntW-1:0] cnt_q;
    logic [ClkCntW-1:0] cpb_q;
    logic [7:0]         shreg_q;
    logic [2:0]         bit_idx_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [7:0]         fifo_rdata;
    logic               fifo_push;
    logic               fifo_pop;
    logic               cnt_last;
    logic [ClkCntW-1:0] cpb_sel;

    assign tx_ready_o = !fifo_full;
    assign fifo_push  = tx_valid_i && tx_ready_o;
    assign cnt_last   = (cnt_q == (cpb_q - ClkCntW'(1)));
    assign cpb_sel    = (clks_per_bit_i == '0) ? ClkCntW'(1) : clks_per_bit_i;
    // A byte leaves the FIFO when idle, or at the last stop-bit cycle so frames run back-to-back.
    assign fifo_pop   = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && cnt_last));

    prog_tx_fifo #(
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk_i         (clk_i),
        .system_rst_ni (system_rst_ni),
        .push_i        (fifo_push),
        .data_i        (tx_byte_i),
        .pop_i         (fifo_pop),
        .data_o        (fifo_rdata),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .level_o       (fifo_level_o)
    );

    // Frame sequencer: bit timing, LSB-first shifting and registered line/status outputs.
    always_ff @(posedge clk_i or negedge system_rst_ni) begin
        if (!system_rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cpb_q       <= ClkCntW'(1);
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            tx_serial_o <= 1'b1;
            tx_active_o <= 1'b0;
            tx_done_o   <= 1'b0;
        end else begin
            tx_done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_serial_o <= 1'b1;
                    if (!fifo_empty) begin
                        shreg_q     <= fifo_rdata;
                        cpb_q       <= cpb_sel;
                        cnt_q       <= '0;
                        tx_serial_o <= 1'b0;
                        tx_active_o <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        cnt_q       <= '0;
                        bit_idx_q   <= '0;
                        tx_serial_o <= shreg_q[0];
                        state_q     <= DATA;
                    end else begin
                        cnt_q <= cnt_q + ClkCntW'(1);
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                            tx_serial_o <= 1'b1;
                            state_q     <= STOP;
                            // done marks the final stop cycle, which is the first one when cpb is 1
                            tx_done_o   <= (cpb_q == ClkCntW'(1));
                        end else begin
                            shreg_q     <= {1'b0, shreg_q[7:1]};
                            tx_serial_o <= shreg_q[1];
                            bit_idx_q   <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + ClkCntW'(1);
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        cnt_q <= '0;
                        if (!fifo_empty) begin
                            shreg_q     <= fifo_rdata;
                            cpb_q       <= cpb_sel;
                            tx_serial_o <= 1'b0;
                            state_q     <= START;
                        end else begin
                            tx_serial_o <= 1'b1;
                            tx_active_o <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end else begin
                        cnt_q     <= cnt_q + ClkCntW'(1);
                        tx_done_o <= ((cnt_q + ClkCntW'(1)) == (cpb_q - ClkCntW'(1)));
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    tx_serial_o <= 1'b1;
                    tx_active_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_transmitter.sv
// Randomized self-checking bench for uart_prog_transmitter against a frame-level model.
module tb_uart_prog_transmitter;

    localparam int unsigned FD      = 8;
    localparam int unsigned CW      = 16;
    localparam int unsigned FRAME_B = 10;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] cpb;
    logic          valid;
    logic [7:0]    byte_in;
    logic          ready;
    logic          serial;
    logic          active;
    logic          done;
    logic [3:0]    level;

    int unsigned n_tests;
    int unsigned n_fail;
    string       phase;

    // Reference model: bytes waiting, and the frame currently on the line.
    logic [7:0]  mq[$];
    bit          m_busy;
    int unsigned m_pos;
    int unsigned m_cpb;
    logic [7:0]  m_cur;

    uart_prog_transmitter #(
        .FifoDepth (FD),
        .ClkCntW   (CW)
    ) dut (
        .clk_i          (clk),
        .system_rst_ni  (rst_n),
        .clks_per_bit_i (cpb),
        .tx_valid_i     (valid),
        .tx_byte_i      (byte_in),
        .tx_ready_o     (ready),
        .tx_serial_o    (serial),
        .tx_active_o    (active),
        .tx_done_o      (done),
        .fifo_level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_busy = 1'b0;
        m_pos  = 0;
    endtask

    function automatic logic exp_line();
        int unsigned bi;
        if (!m_busy) return 1'b1;
        bi = m_pos / m_cpb;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return m_cur[bi-1];
        return 1'b1;
    endfunction

    // One clock: advance the model at the rising edge, compare outputs at the falling edge.
    task automatic step();
        bit take;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            take = valid && (mq.size() < FD);
            if (m_busy) begin
                m_pos++;
                if (m_pos == FRAME_B * m_cpb) m_busy = 1'b0;
            end
            if (!m_busy && mq.size() > 0) begin
                m_cur  = mq.pop_front();
                m_cpb  = (cpb == 0) ? 1 : int'(cpb);
                m_pos  = 0;
                m_busy = 1'b1;
            end
            if (take) mq.push_back(byte_in);
        end
        @(negedge clk);
        check({phase, ".line"},   32'(serial), 32'(exp_line()));
        check({phase, ".active"}, 32'(active), 32'(m_busy));
        check({phase, ".done"},   32'(done),   32'(m_busy && (m_pos == FRAME_B * m_cpb - 1)));
        check({phase, ".level"},  32'(level),  32'(mq.size()));
        check({phase, ".ready"},  32'(ready),  32'(mq.size() < FD));
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic push1(input logic [7:0] b);
        valid   = 1'b1;
        byte_in = b;
        step();
        valid   = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        valid   = 1'b0;
        byte_in = '0;
        cpb     = CW'(4);
        model_clear();

        phase = "reset";
        run(3);
        rst_n = 1'b1;

        phase = "t1_a5";
        push1(8'hA5);
        run(45);

        phase = "t2_b2b";
        cpb = CW'(3);
        valid = 1'b1;
        byte_in = 8'h00; step();
        byte_in = 8'hFF; step();
        byte_in = 8'h55; step();
        valid = 1'b0;
        run(100);

        phase = "t3_fill";
        cpb = CW'(1000);
        valid = 1'b1;
        for (int unsigned i = 0; i < 12; i++) begin
            byte_in = 8'($urandom);
            step();
        end
        valid = 1'b0;
        check("t3.level_full", 32'(level), 32'(FD));
        check("t3.ready_low",  32'(ready), 32'd0);
        cpb = CW'(2);
        run(10000 + 8 * 20 + 20);

        phase = "t4_cpb0";
        cpb = '0;
        push1(8'h81);
        run(15);

        phase = "t5_cpbchg";
        cpb = CW'(8);
        valid = 1'b1;
        byte_in = 8'h3A; step();
        byte_in = 8'hC5; step();
        valid = 1'b0;
        run(18);
        cpb = CW'(2);
        run(110);

        phase = "t6_rst";
        cpb = CW'(8);
        valid = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            byte_in = 8'($urandom);
            step();
        end
        valid = 1'b0;
        run(33);
        #2 rst_n = 1'b0;
        #1;
        check("t6.async_line",   32'(serial), 32'd1);
        check("t6.async_active", 32'(active), 32'd0);
        check("t6.async_done",   32'(done),   32'd0);
        check("t6.async_level",  32'(level),  32'd0);
        check("t6.async_ready",  32'(ready),  32'd1);
        run(2);
        rst_n = 1'b1;
        push1(8'h3C);
        run(90);

        phase = "rand";
        for (int unsigned i = 0; i < 3000; i++) begin
            if (i % 300 == 0) cpb = CW'($urandom_range(0, 6));
            valid   = ($urandom_range(0, 3) == 0);
            byte_in = 8'($urandom);
            step();
        end
        valid = 1'b0;
        run(FRAME_B * 6 * (FD + 2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
